// File: rtl/sdram_pkg.sv
// Shared SDRAM constants: command encodings, bus widths and the arbiter state encoding.
package sdram_pkg;

    localparam int ROW_W  = 13;
    localparam int COL_W  = 9;
    localparam int BANK_W = 2;
    localparam int CMD_W  = 4;
    localparam int DQ_W   = 16;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } arb_state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } rw_grant_t;

endpackage

// File: rtl/sdram_cmd_mux.sv
// Combinational state-to-pins mux: routes the owning engine's cmd/addr/bank and the
// write data enable onto the SDRAM pins; NOP while arbitrating.
module sdram_cmd_mux
    import sdram_pkg::*;
(
    input  arb_state_t         state,
    input  logic [CMD_W-1:0]   init_cmd,
    input  logic [ROW_W-1:0]   init_addr,
    input  logic [CMD_W-1:0]   ref_cmd,
    input  logic [ROW_W-1:0]   ref_addr,
    input  logic [CMD_W-1:0]   wr_cmd,
    input  logic [ROW_W-1:0]   wr_addr,
    input  logic [BANK_W-1:0]  wr_bank,
    input  logic               wr_data_oe,
    input  logic [CMD_W-1:0]   rd_cmd,
    input  logic [ROW_W-1:0]   rd_addr,
    input  logic [BANK_W-1:0]  rd_bank,
    output logic [CMD_W-1:0]   sdram_cmd,
    output logic [ROW_W-1:0]   sdram_addr,
    output logic [BANK_W-1:0]  sdram_bank,
    output logic               sdram_dq_oe
);

    always_comb begin
        sdram_cmd   = CMD_NOP;
        sdram_addr  = '0;
        sdram_bank  = '0;
        sdram_dq_oe = 1'b0;
        unique case (state)
            S_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            S_AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
            end
            S_WRITE: begin
                sdram_cmd   = wr_cmd;
                sdram_addr  = wr_addr;
                sdram_bank  = wr_bank;
                sdram_dq_oe = wr_data_oe;
            end
            S_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: init hold-off, refresh-first grant FSM with grant timeout.
// Define SDRAM_ARB_RR_EN for round-robin write/read priority (default: write over read).
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic               sclk,
    input  logic               s_rst_n,
    input  logic               init_end,
    input  logic [CMD_W-1:0]   init_cmd,
    input  logic [ROW_W-1:0]   init_addr,
    input  logic               ref_req,
    input  logic               ref_end,
    input  logic [CMD_W-1:0]   ref_cmd,
    input  logic [ROW_W-1:0]   ref_addr,
    output logic               ref_en,
    input  logic               wr_req,
    input  logic               wr_end,
    input  logic [CMD_W-1:0]   wr_cmd,
    input  logic [ROW_W-1:0]   wr_addr,
    input  logic [BANK_W-1:0]  wr_bank,
    input  logic [DQ_W-1:0]    wr_data,
    input  logic               wr_data_oe,
    output logic               wr_en,
    input  logic               rd_req,
    input  logic               rd_end,
    input  logic [CMD_W-1:0]   rd_cmd,
    input  logic [ROW_W-1:0]   rd_addr,
    input  logic [BANK_W-1:0]  rd_bank,
    output logic               rd_en,
    output logic               sdram_cke,
    output logic [CMD_W-1:0]   sdram_cmd,
    output logic [ROW_W-1:0]   sdram_addr,
    output logic [BANK_W-1:0]  sdram_bank,
    output logic [DQ_W-1:0]    sdram_dq_out,
    output logic               sdram_dq_oe,
    output logic               arb_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t       state_reg;
    arb_state_t       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             arb_err_reg;
    logic             cke_reg;
    logic             granted;
    logic             end_hit;
    logic             timeout_hit;
    logic             pick_rd;

`ifdef SDRAM_ARB_RR_EN
    rw_grant_t last_grant_reg;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            last_grant_reg <= GRANT_RD;
        end else if (state_reg == S_ARBIT && state_next == S_WRITE) begin
            last_grant_reg <= GRANT_WR;
        end else if (state_reg == S_ARBIT && state_next == S_READ) begin
            last_grant_reg <= GRANT_RD;
        end
    end

    assign pick_rd = (last_grant_reg == GRANT_WR);
`else
    assign pick_rd = 1'b0;
`endif

    always_comb begin
        granted     = (state_reg == S_AREF) || (state_reg == S_WRITE) || (state_reg == S_READ);
        end_hit     = ((state_reg == S_AREF)  && ref_end) ||
                      ((state_reg == S_WRITE) && wr_end)  ||
                      ((state_reg == S_READ)  && rd_end);
        // Fires on the last allowed cycle so the grant lasts exactly TIMEOUT_CYC cycles.
        timeout_hit = granted && (cnt_reg == CNT_LAST);
        state_next  = state_reg;
        unique case (state_reg)
            S_INIT: begin
                if (init_end) state_next = S_ARBIT;
            end
            S_ARBIT: begin
                if (ref_req)                state_next = S_AREF;
                else if (wr_req && rd_req)  state_next = pick_rd ? S_READ : S_WRITE;
                else if (wr_req)            state_next = S_WRITE;
                else if (rd_req)            state_next = S_READ;
            end
            S_AREF, S_WRITE, S_READ: begin
                if (end_hit || timeout_hit) state_next = S_ARBIT;
            end
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_reg   <= S_INIT;
            cnt_reg     <= '0;
            arb_err_reg <= 1'b0;
            cke_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cke_reg     <= 1'b1;
            arb_err_reg <= timeout_hit && !end_hit;
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (granted && cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign ref_en       = (state_reg == S_AREF);
    assign wr_en        = (state_reg == S_WRITE);
    assign rd_en        = (state_reg == S_READ);
    assign arb_err      = arb_err_reg;
    assign sdram_cke    = cke_reg;
    assign sdram_dq_out = wr_data;

    sdram_cmd_mux u_cmd_mux (
        .state       (state_reg),
        .init_cmd    (init_cmd),
        .init_addr   (init_addr),
        .ref_cmd     (ref_cmd),
        .ref_addr    (ref_addr),
        .wr_cmd      (wr_cmd),
        .wr_addr     (wr_addr),
        .wr_bank     (wr_bank),
        .wr_data_oe  (wr_data_oe),
        .rd_cmd      (rd_cmd),
        .rd_addr     (rd_addr),
        .rd_bank     (rd_bank),
        .sdram_cmd   (sdram_cmd),
        .sdram_addr  (sdram_addr),
        .sdram_bank  (sdram_bank),
        .sdram_dq_oe (sdram_dq_oe)
    );

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM command/address/data bus between the initialisation, auto-refresh, write-burst and read-burst engines of the image system. It holds all engines off until power-up init completes, then grants the bus to one requester at a time and muxes the granted engine's command, address and bank onto the SDRAM pins. Refresh always wins. Write/read priority is fixed or round-robin, selected at build time.

## Interface
- TIMEOUT_CYC, 1023: maximum grant length in cycles before forced release.
- sclk  in  1  system clock (SDRAM clock domain).
- s_rst_n  in  1  reset, asynchronous, active-low.
- init_end  in  1  level; high once the init engine has finished.
- init_cmd / init_addr  in  4 / 13  init engine command and address.
- ref_req  in  1  refresh engine request (level, held until granted).
- ref_end  in  1  one-cycle pulse; refresh sequence done.
- ref_cmd / ref_addr  in  4 / 13  refresh engine command and address.
- ref_en  out  1  refresh grant.
- wr_req / wr_end  in  1 / 1  write engine request (level) and done pulse.
- wr_cmd / wr_addr / wr_bank  in  4 / 13 / 2  write engine bus.
- wr_data / wr_data_oe  in  16 / 1  write data and drive enable.
- wr_en  out  1  write grant.
- rd_req / rd_end  in  1 / 1  read engine request (level) and done pulse.
- rd_cmd / rd_addr / rd_bank  in  4 / 13 / 2  read engine bus.
- rd_en  out  1  read grant.
- sdram_cke  out  1  clock enable.
- sdram_cmd  out  4  {cs_n, ras_n, cas_n, we_n}.
- sdram_addr / sdram_bank  out  13 / 2  SDRAM address and bank pins.
- sdram_dq_out / sdram_dq_oe  out  16 / 1  data pin drive and enable.
- arb_err  out  1  one-cycle pulse on grant timeout.

## Operation
- State machine states: S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ (one-hot).
- S_INIT:
  - Bus carries init_cmd and init_addr; bank is 0.
  - Move to S_ARBIT on the first cycle init_end=1.
- S_ARBIT:
  - Bus carries NOP 4'b0111, addr 0, bank 0.
  - ref_req=1 → S_AREF.
  - Else, with only one of wr_req/rd_req high, go to its state (S_WRITE or S_READ).
  - With both high, the choice is set by Configuration.
- S_AREF, S_WRITE, S_READ:
  - The granted engine's cmd, addr and bank go straight to the pins through a combinational mux.
  - ref_en, wr_en, rd_en are decoded from the state register: high exactly while in the matching state.
  - The matching *_end pulse returns the FSM to S_ARBIT.
  - *_end pulses from engines that are not granted are ignored.
- Grant timeout:
  - A grant counter clears on entry to each grant state and increments every cycle while in it.
  - When the counter reaches TIMEOUT_CYC, force S_ARBIT and pulse arb_err.
  - Counter width is clog2(TIMEOUT_CYC+1) and must not wrap.
- Data pins:
  - sdram_dq_out = wr_data always.
  - sdram_dq_oe = wr_data_oe only in S_WRITE, else 0.
- sdram_cke is a register: 0 in reset, 1 from the first sclk edge after reset release.
- Requests are not latched. Each engine holds *_req high until it sees its *_en.

## Timing
- Reset values:
  - state = S_INIT.
  - All *_en = 0, arb_err = 0, sdram_cke = 0, sdram_dq_oe = 0.
  - Pins carry init_cmd and init_addr, which the init engine holds at NOP during reset.
- Grant latency: a request sampled at edge t in S_ARBIT gives *_en = 1 from edge t onward. The minimum is one cycle spent in S_ARBIT.
- Release: an *_end sampled at edge t gives *_en = 0 after edge t. S_ARBIT always lasts at least one cycle, so one NOP separates back-to-back grants.
- Simultaneous events:
  - *_end and timeout in the same cycle: normal release, no arb_err.
  - ref_req with wr_req and/or rd_req: S_AREF.
- Reset mid-grant: immediate return to S_INIT, all enables low, and init runs again.

## Configuration
- SDRAM_ARB_RR_EN defined: a last_grant register is updated on each entry to S_WRITE or S_READ (reset value: READ). When wr_req and rd_req are both high, the engine not granted last wins.
- SDRAM_ARB_RR_EN undefined: fixed priority, write over read. The last_grant register is not built.
- Refresh priority is the same in both builds.

## Structure
- Shared package sdram_pkg holds:
  - the CMD_NOP/PRE/AREF/ACT/RD/WR constants (4'b0111, 4'b0010, 4'b0001, 4'b0011, 4'b0101, 4'b0100);
  - the arbiter state encodings;
  - the ROW/COL width constants.
- One sub-module, sdram_cmd_mux: the combinational state-to-pins mux for cmd, addr, bank and dq_oe. The FSM, counter and priority logic stay in sdram_arbiter.

## Test plan
- Init hold: pulse reset, hold init_end=0 for 200 cycles with wr_req=1 → wr_en stays 0 and pins follow init_cmd. Raise init_end → wr_en=1 two edges later.
- Refresh pre-emption order: in S_ARBIT, drive ref_req=wr_req=rd_req=1 in the same cycle → ref_en first. After ref_end, wr_en in the fixed build; the same result in the RR build with last_grant=READ.
- Round-robin (SDRAM_ARB_RR_EN): hold wr_req=rd_req=1 continuously, ending each grant after 10 cycles → grants alternate W, R, W, R, each separated by exactly one NOP cycle.
- Mux correctness: in S_READ, rd_cmd=4'b0101, rd_addr=13'h1A5, rd_bank=2 → identical values on the pins the same cycle, with sdram_dq_oe=0.
- Timeout: TIMEOUT_CYC=15, grant write and never pulse wr_end → after 15 cycles, wr_en drops and arb_err pulses once. A stray rd_end during the grant has no effect.
- Reset mid-write: assert s_rst_n=0 during S_WRITE → wr_en, sdram_dq_oe and sdram_cke go 0 asynchronously, and the FSM re-enters S_INIT.
